// File: rtl/wind_pkg.sv
// rtl/wind_pkg.sv - shared widths, FSM states and phase/speed helpers; WIND_SAT_EN selects saturating speed resize
package wind_pkg;

   localparam int DEF_PW    = 19;
   localparam int DEF_SW    = 16;
   localparam int ACC_GUARD = 15;

   typedef enum logic {
      IDLE = 1'b0,
      DIFF = 1'b1
   } wind_state_e;

   // Modulo-2pi difference: wrap to pw bits, then sign-extend back to 32
   function automatic logic signed [31:0] wrap_diff(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned        pw);
      logic signed [31:0] d;
      d = a - b;
      return (d <<< (32 - pw)) >>> (32 - pw);
   endfunction

   function automatic logic signed [31:0] resize_speed(input logic signed [63:0] v,
                                                      input int unsigned        sw);
`ifdef WIND_SAT_EN
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (sw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return 32'(hi);
      if (v < lo) return 32'(lo);
      return 32'(v);
`else
      return 32'((v <<< (64 - sw)) >>> (64 - sw));
`endif
   endfunction

endpackage

// File: rtl/wind_multiaxis_avg_if.sv
// rtl/wind_multiaxis_avg_if.sv - speed output stream with valid/ready handshake
interface wind_multiaxis_avg_if #(
   parameter int SW = 16
);
   logic signed [SW-1:0] speed;
   logic [2:0]           speed_axis;
   logic                 speed_valid;
   logic                 speed_ready;

   modport master (
      output speed,
      output speed_axis,
      output speed_valid,
      input  speed_ready
   );

   modport slave (
      input  speed,
      input  speed_axis,
      input  speed_valid,
      output speed_ready
   );
endinterface

// File: rtl/wind_avg_bank.sv
// rtl/wind_avg_bank.sv - per-axis accumulators, window counter, shift-average and draining holding bank
module wind_avg_bank
   import wind_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int PW       = DEF_PW,
   parameter int SW       = DEF_SW,
   parameter int SCALE_SH = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    capture,
   input  logic                    add_en,
   input  logic [$clog2(N_CH)-1:0] add_axis,
   input  logic signed [31:0]      add_val,
   input  logic                    sample_done,
   input  logic [3:0]              spdmeanlen,
   output logic signed [SW-1:0]    speed,
   output logic [2:0]              speed_axis,
   output logic                    speed_valid,
   input  logic                    speed_ready,
   output logic                    bank_ovr
);
   localparam int AXW = $clog2(N_CH);
   localparam int AW  = PW + ACC_GUARD;
   localparam logic [AXW-1:0] LAST_AX = AXW'(N_CH - 1);

   logic signed [AW-1:0] acc  [N_CH];
   logic signed [AW-1:0] avg  [N_CH];
   logic signed [31:0]   rs   [N_CH];
   logic signed [SW-1:0] nxt  [N_CH];
   logic signed [SW-1:0] hold [N_CH];
   logic [15:0]          cnt;
   logic [3:0]           len_l;
   logic                 done_q;
   logic [AXW-1:0]       ptr;

   // Window completion is registered one cycle after the last add, so the
   // accumulators already hold the final sample when the bank is loaded.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         len_l  <= '0;
         done_q <= 1'b0;
         for (int k = 0; k < N_CH; k++) acc[k] <= '0;
      end else begin
         if (capture && (cnt == '0 || done_q)) len_l <= spdmeanlen;
         done_q <= sample_done && (({1'b0, cnt} + 17'd1) == (17'd1 << len_l));
         if (done_q)
            cnt <= '0;
         else if (sample_done)
            cnt <= cnt + 16'd1;
         for (int k = 1; k < N_CH; k++) begin
            if (done_q)
               acc[k] <= '0;
            else if (add_en && int'(add_axis) == k)
               acc[k] <= acc[k] + AW'(add_val);
         end
      end
   end

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         avg[k] = (acc[k] >>> len_l) >>> SCALE_SH;
         rs[k]  = resize_speed(64'(avg[k]), SW);
         nxt[k] = SW'(rs[k]);
      end
   end

   assign bank_ovr   = done_q && speed_valid;
   assign speed_axis = 3'(ptr);

   // A new set is only accepted once the previous one has fully drained
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         speed_valid <= 1'b0;
         speed       <= '0;
         ptr         <= '0;
         for (int k = 0; k < N_CH; k++) hold[k] <= '0;
      end else if (done_q && !speed_valid) begin
         for (int k = 0; k < N_CH; k++) hold[k] <= nxt[k];
         speed       <= nxt[1];
         ptr         <= AXW'(1);
         speed_valid <= 1'b1;
      end else if (speed_valid && speed_ready) begin
         if (ptr == LAST_AX) begin
            speed_valid <= 1'b0;
         end else begin
            ptr   <= ptr + 1'b1;
            speed <= hold[ptr + 1'b1];
         end
      end
   end

endmodule

// File: rtl/wind_multiaxis_avg.sv
// rtl/wind_multiaxis_avg.sv - N-channel phase capture, shared subtractor FSM and averaging back end; WIND_SAT_EN saturates speed
module wind_multiaxis_avg
   import wind_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int PW       = DEF_PW,
   parameter int SW       = DEF_SW,
   parameter int SCALE_SH = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 endata,
   input  logic [3:0]           spdmeanlen,
   input  logic [N_CH*PW-1:0]   phase_in,
   wind_multiaxis_avg_if.master spd,
   output logic                 overrun
);
   localparam int AXW = $clog2(N_CH);
   localparam logic [AXW-1:0] LAST_AX = AXW'(N_CH - 1);

   wind_state_e          state, state_nxt;
   logic [AXW-1:0]       ax, ax_nxt;
   logic signed [PW-1:0] cap [N_CH];
   logic                 capture;
   logic                 samp_ovr;
   logic                 add_en;
   logic                 sample_done;
   logic                 bank_ovr;
   logic signed [31:0]   diff_w;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         ax      <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         ax      <= ax_nxt;
         overrun <= samp_ovr || bank_ovr;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N_CH; k++) cap[k] <= '0;
      end else if (capture) begin
         for (int k = 0; k < N_CH; k++) cap[k] <= phase_in[k*PW +: PW];
      end
   end

   always_comb begin
      state_nxt   = state;
      ax_nxt      = ax;
      capture     = 1'b0;
      samp_ovr    = 1'b0;
      add_en      = 1'b0;
      sample_done = 1'b0;
      case (state)
         IDLE: begin
            if (endata) begin
               capture   = 1'b1;
               state_nxt = DIFF;
               ax_nxt    = AXW'(1);
            end
         end
         DIFF: begin
            add_en   = 1'b1;
            samp_ovr = endata;
            if (ax == LAST_AX) begin
               sample_done = 1'b1;
               state_nxt   = IDLE;
            end else begin
               ax_nxt = ax + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One subtractor, walked across the axes while in DIFF
   assign diff_w = wrap_diff(32'(cap[ax]), 32'(cap[0]), PW);

   wind_avg_bank #(
      .N_CH     (N_CH),
      .PW       (PW),
      .SW       (SW),
      .SCALE_SH (SCALE_SH)
   ) u_bank (
      .clock       (clock),
      .reset       (reset),
      .capture     (capture),
      .add_en      (add_en),
      .add_axis    (ax),
      .add_val     (diff_w),
      .sample_done (sample_done),
      .spdmeanlen  (spdmeanlen),
      .speed       (spd.speed),
      .speed_axis  (spd.speed_axis),
      .speed_valid (spd.speed_valid),
      .speed_ready (spd.speed_ready),
      .bank_ovr    (bank_ovr)
   );

endmodule

// File: tb/tb_wind_multiaxis_avg.sv
// tb/tb_wind_multiaxis_avg.sv - randomized scoreboard bench for wind_multiaxis_avg
module tb_wind_multiaxis_avg;
   localparam int N_CH     = 4;
   localparam int PW       = 19;
   localparam int SW       = 16;
   localparam int SCALE_SH = 3;

   typedef struct {
      longint axis;
      longint spd;
   } word_t;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               endata = 1'b0;
   logic [3:0]         spdmeanlen = 4'd0;
   logic [N_CH*PW-1:0] phase_in = '0;
   logic               overrun;

   logic               endata2 = 1'b0;
   logic [3:0]         spdmeanlen2 = 4'd0;
   logic [2*PW-1:0]    phase2 = '0;
   logic               overrun2;

   wind_multiaxis_avg_if #(.SW(SW)) sif ();
   wind_multiaxis_avg_if #(.SW(SW)) sif2 ();

   wind_multiaxis_avg #(.N_CH(N_CH), .PW(PW), .SW(SW), .SCALE_SH(SCALE_SH)) dut (
      .clock(clock), .reset(reset), .endata(endata), .spdmeanlen(spdmeanlen),
      .phase_in(phase_in), .spd(sif), .overrun(overrun)
   );

   wind_multiaxis_avg #(.N_CH(2), .PW(PW), .SW(SW), .SCALE_SH(0)) dut_sat (
      .clock(clock), .reset(reset), .endata(endata2), .spdmeanlen(spdmeanlen2),
      .phase_in(phase2), .spd(sif2), .overrun(overrun2)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int     n_chk = 0;
   int     n_pass = 0;
   int     exp_ovr = 0;
   int     got_ovr = 0;
   word_t  sb[$];
   longint msum [N_CH];
   int     mcount = 0;
   int     mlen = 0;
   int     last_cap = -100;
   bit     stall = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic longint wrapd(input longint a, input longint b);
      longint m;
      longint r;
      m = longint'(1) << PW;
      r = (a - b + m / 2) % m;
      if (r < 0) r += m;
      return r - m / 2;
   endfunction

   function automatic longint floordiv(input longint a, input longint d);
      longint q;
      q = a / d;
      if ((a % d) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   function automatic longint fit_sw(input longint v);
      longint m;
      longint r;
      m = longint'(1) << SW;
`ifdef WIND_SAT_EN
      if (v > m / 2 - 1) return m / 2 - 1;
      if (v < -(m / 2)) return -(m / 2);
      r = v;
      return r;
`else
      r = (v + m / 2) % m;
      if (r < 0) r += m;
      return r - m / 2;
`endif
   endfunction

   function automatic longint rnd_phase();
      return longint'($urandom_range(0, (1 << PW) - 1)) - (longint'(1) << (PW - 1));
   endfunction

   task automatic model_clear();
      for (int k = 0; k < N_CH; k++) msum[k] = 0;
      mcount   = 0;
      last_cap = -100;
   endtask

   // Sample accepted only if the previous accepted one was N_CH or more edges earlier
   task automatic model_sample(input longint p [N_CH], input int edge_n);
      word_t w;
      if (edge_n - last_cap < N_CH) begin
         exp_ovr++;
         return;
      end
      last_cap = edge_n;
      if (mcount == 0) mlen = int'(spdmeanlen);
      for (int k = 1; k < N_CH; k++) msum[k] += wrapd(p[k], p[0]);
      mcount++;
      if (mcount == (1 << mlen)) begin
         if (stall && sb.size() != 0) begin
            exp_ovr++;
         end else begin
            for (int k = 1; k < N_CH; k++) begin
               w.axis = k;
               w.spd  = fit_sw(floordiv(floordiv(msum[k], longint'(1) << mlen),
                                        longint'(1) << SCALE_SH));
               sb.push_back(w);
            end
         end
         for (int k = 0; k < N_CH; k++) msum[k] = 0;
         mcount = 0;
      end
   endtask

   task automatic issue(input longint p [N_CH], input int spacing);
      int edge_n;
      @(posedge clock); #1;
      for (int k = 0; k < N_CH; k++) phase_in[k*PW +: PW] = PW'(p[k]);
      endata = 1'b1;
      edge_n = cyc + 1;
      model_sample(p, edge_n);
      @(posedge clock); #1;
      endata = 1'b0;
      repeat (spacing - 2) @(posedge clock);
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(posedge clock);
         t++;
      end
      if (sb.size() != 0) begin
         n_chk++;
         $display("FAIL %s_drain: %0d words still outstanding, required 0", name, sb.size());
         sb.delete();
      end
      repeat (6) @(posedge clock);
      check({name, "_overrun_count"}, got_ovr, exp_ovr);
   endtask

   // Monitor: pops the scoreboard on every handshake, checks stability under stall
   initial begin
      word_t  w;
      bit     held = 1'b0;
      longint prev_spd = 0;
      longint prev_axis = 0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            held = 1'b0;
         end else begin
            if (overrun) got_ovr++;
            if (sif.speed_valid) begin
               if (held) begin
                  check("stall_speed", sif.speed, prev_spd);
                  check("stall_axis", sif.speed_axis, prev_axis);
               end
               if (sif.speed_ready) begin
                  held = 1'b0;
                  if (sb.size() == 0) begin
                     n_chk++;
                     $display("FAIL unexpected_word: got axis %0d speed %0d, required no word",
                              sif.speed_axis, sif.speed);
                  end else begin
                     w = sb.pop_front();
                     check("word_axis", sif.speed_axis, w.axis);
                     check("word_speed", sif.speed, w.spd);
                  end
               end else begin
                  held      = 1'b1;
                  prev_spd  = sif.speed;
                  prev_axis = sif.speed_axis;
               end
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      longint pv [N_CH];
      int     t;
      sif.speed_ready  = 1'b1;
      sif2.speed_ready = 1'b1;
      model_clear();

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_speed", sif.speed, 0);
      check("rst_axis", sif.speed_axis, 0);
      check("rst_valid", sif.speed_valid, 0);
      check("rst_overrun", overrun, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);

      // Saturation / wrap of the resize on the SCALE_SH=0 instance
      @(posedge clock); #1;
      phase2[0 +: PW]  = PW'(0);
      phase2[PW +: PW] = PW'(40000);
      endata2 = 1'b1;
      @(posedge clock); #1;
      endata2 = 1'b0;
      t = 0;
      @(negedge clock);
      while (!sif2.speed_valid && t < 30) begin
         @(negedge clock);
         t++;
      end
      if (!sif2.speed_valid) begin
         n_chk++;
         $display("FAIL sat_timeout: speed_valid low after %0d cycles, required high", t);
      end else begin
         check("sat_speed", sif2.speed, fit_sw(wrapd(40000, 0)));
         check("sat_axis", sif2.speed_axis, 1);
      end

      // Basic averaging over 4 samples
      spdmeanlen = 4'd2;
      pv = '{0, 800, -800, 0};
      for (int i = 0; i < 4; i++) issue(pv, 6);
      wait_drain("basic");

      // Wrap across +/-pi
      spdmeanlen = 4'd0;
      pv = '{262044, -262044, rnd_phase(), rnd_phase()};
      issue(pv, 6);
      wait_drain("wrap");

      // Backpressure: old set held while a second window completes and is dropped
      stall = 1'b1;
      sif.speed_ready = 1'b0;
      pv = '{rnd_phase(), rnd_phase(), rnd_phase(), rnd_phase()};
      issue(pv, 6);
      repeat (8) @(posedge clock);
      pv = '{rnd_phase(), rnd_phase(), rnd_phase(), rnd_phase()};
      issue(pv, 6);
      repeat (8) @(posedge clock);
      stall = 1'b0;
      #1 sif.speed_ready = 1'b1;
      wait_drain("backpressure");

      // Sample overrun: strobes 2 cycles apart, third one lands back in IDLE
      spdmeanlen = 4'd1;
      for (int i = 0; i < 3; i++) begin
         pv = '{rnd_phase(), rnd_phase(), rnd_phase(), rnd_phase()};
         issue(pv, 2);
      end
      wait_drain("sample_overrun");

      // Reset mid-window, then a clean window
      spdmeanlen = 4'd2;
      for (int i = 0; i < 3; i++) begin
         pv = '{rnd_phase(), rnd_phase(), rnd_phase(), rnd_phase()};
         issue(pv, 6);
      end
      @(posedge clock); #3;
      reset = 1'b0;
      model_clear();
      @(negedge clock);
      check("midrst_speed", sif.speed, 0);
      check("midrst_axis", sif.speed_axis, 0);
      check("midrst_valid", sif.speed_valid, 0);
      check("midrst_overrun", overrun, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pv = '{rnd_phase(), rnd_phase(), rnd_phase(), rnd_phase()};
         issue(pv, 6);
      end
      wait_drain("after_reset");

      // Randomized phases, spacing and window lengths (mid-window length changes)
      for (int i = 0; i < 40; i++) begin
         spdmeanlen = 4'($urandom_range(0, 3));
         pv = '{rnd_phase(), rnd_phase(), rnd_phase(), rnd_phase()};
         issue(pv, int'($urandom_range(2, 8)));
      end
      wait_drain("random");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
